// File: rtl/prime_scan_ctrl.sv
// prime_scan_ctrl
//   Scans the inclusive range [lo, hi] and streams every prime it finds,
//   in ascending order. Primality is decided by trial division with odd
//   divisors only. Each remainder is built by repeated subtraction, one
//   subtraction per clock, so no divider is needed.
//
// Ports
//   clk, rst     : clock; asynchronous active-high reset
//   start        : scan request, sampled only while idle
//   lo, hi       : range bounds, captured when start is accepted
//   out_ready    : consumer accepts out_prime this cycle
//   busy         : scan in progress (every state except IDLE and DONE)
//   out_valid    : out_prime holds a prime waiting to be taken
//   out_prime    : prime value
//   done         : one-cycle pulse when the scan finishes
//   prime_count  : number of primes transferred in the current/last scan
//
// Output handshake: while out_valid=1, out_prime holds steady. A transfer
// happens on each rising edge where out_valid=1 and out_ready=1. The scan
// waits in EMIT for as long as out_ready stays low.
module prime_scan_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  input  logic         out_ready,
  output logic         busy,
  output logic         out_valid,
  output logic [N-1:0] out_prime,
  output logic         done,
  output logic [N-1:0] prime_count
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_CLASSIFY = 3'd2;
  localparam logic [2:0] S_DIV      = 3'd3;
  localparam logic [2:0] S_STEP     = 3'd4;
  localparam logic [2:0] S_EMIT     = 3'd5;
  localparam logic [2:0] S_ADVANCE  = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]   state_q, state_d;
  logic [N-1:0] lo_q, lo_d;
  logic [N-1:0] hi_q, hi_d;
  logic [N-1:0] cand_q, cand_d;
  logic [N-1:0] d_q, d_d;
  logic [N-1:0] rem_q, rem_d;
  logic [N-1:0] out_prime_q, out_prime_d;
  logic [N-1:0] count_q, count_d;

  // The next divisor is d+2. The search can stop once (d+2)^2 > cand.
  // The square is formed at 2N+2 bits, so it never wraps.
  logic [N:0]     d_plus2;
  logic [2*N+1:0] d_plus2_wide;
  logic [2*N+1:0] d_plus2_sq;
  logic [2*N+1:0] cand_wide;

  assign d_plus2      = {1'b0, d_q} + (N+1)'(2);
  assign d_plus2_wide = {{(N+1){1'b0}}, d_plus2};
  assign d_plus2_sq   = d_plus2_wide * d_plus2_wide;
  assign cand_wide    = {{(N+2){1'b0}}, cand_q};

  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    cand_d      = cand_q;
    d_d         = d_q;
    rem_d       = rem_q;
    out_prime_d = out_prime_q;
    count_d     = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          lo_d    = lo;
          hi_d    = hi;
          count_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (lo_q > hi_q) begin
          state_d = S_DONE;
        end else begin
          cand_d  = lo_q;
          state_d = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        if (cand_q < N'(2)) begin
          state_d = S_ADVANCE;
        end else if (cand_q == N'(2) || cand_q == N'(3)) begin
          out_prime_d = cand_q;
          state_d     = S_EMIT;
        end else if (!cand_q[0]) begin
          state_d = S_ADVANCE;
        end else begin
          d_d     = N'(3);
          rem_d   = cand_q;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (rem_q >= d_q) begin
          rem_d = rem_q - d_q;
        end else if (rem_q == '0) begin
          state_d = S_ADVANCE;
        end else begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        d_d = d_plus2[N-1:0];
        if (d_plus2_sq > cand_wide) begin
          out_prime_d = cand_q;
          state_d     = S_EMIT;
        end else begin
          rem_d   = cand_q;
          state_d = S_DIV;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          count_d = count_q + N'(1);
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        // Compare before incrementing so that hi = 2^N-1 ends the scan
        // instead of wrapping cand back to 0.
        if (cand_q == hi_q) begin
          state_d = S_DONE;
        end else begin
          cand_d  = cand_q + N'(1);
          state_d = S_CLASSIFY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      cand_q      <= '0;
      d_q         <= '0;
      rem_q       <= '0;
      out_prime_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      cand_q      <= cand_d;
      d_q         <= d_d;
      rem_q       <= rem_d;
      out_prime_q <= out_prime_d;
      count_q     <= count_d;
    end
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign out_valid   = (state_q == S_EMIT);
  assign done        = (state_q == S_DONE);
  assign out_prime   = out_prime_q;
  assign prime_count = count_q;

endmodule
